// File: rtl/sub_c_pipe.sv
// Per-lane add/accumulate and xor of packed operands, buffered in an output FIFO.
// Latency: one cycle from accept to out_valid when the FIFO is empty (first-word fall-through).
// Backpressure: in_ready depends only on FIFO occupancy, so a pop never re-opens the input in the same cycle.
module sub_c_pipe_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic [W-1:0]  rd_dat,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          wr_en, rd_en;

    assign full   = (level_q == LW'(DEPTH));
    assign empty  = (level_q == '0);
    assign level  = level_q;
    assign rd_dat = mem_q[rd_ptr_q];
    assign wr_en  = wr_vld & ~full;
    assign rd_en  = rd_rdy & ~empty;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        rd_ptr_d = rd_ptr_q + PW'(rd_en);
        level_d  = level_q + LW'(wr_en) - LW'(rd_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_dat;
    end
endmodule

module sub_c_pipe #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4,
    localparam int SW      = CHANNELS * (WIDTH + 1),
    localparam int XW      = CHANNELS * WIDTH,
    localparam int LW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] in_a,
    input  logic [XW-1:0] in_b,
    input  logic [XW-1:0] in_c,
    input  logic          acc_en,
    input  logic          acc_clr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sum,
    output logic [XW-1:0] out_xor,
    output logic [LW-1:0] fifo_level,
    output logic [15:0]   sample_cnt
);
    localparam int EW = SW + XW;

    logic [CHANNELS-1:0][WIDTH:0] acc_q, acc_d;
    logic [CHANNELS-1:0][WIDTH:0] lane_a, lane_b, lane_base, lane_sum;
    logic [SW-1:0]  sum_dat;
    logic [XW-1:0]  xor_dat;
    logic [EW-1:0]  head_dat, hold_q, hold_d;
    logic [15:0]    sample_cnt_q, sample_cnt_d;
    logic           accept, pop, full, empty;

    assign in_ready  = rst_n & ~full;
    assign accept    = in_valid & in_ready;
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;

    // A clear coinciding with an accept zeroes the base before the add.
    always_comb begin
        acc_d     = acc_q;
        lane_a    = '0;
        lane_b    = '0;
        lane_base = '0;
        lane_sum  = '0;
        sum_dat   = '0;
        xor_dat   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            lane_a[i]    = {1'b0, in_a[i*WIDTH +: WIDTH]};
            lane_b[i]    = {1'b0, in_b[i*WIDTH +: WIDTH]};
            lane_base[i] = acc_clr ? '0 : acc_q[i];
            lane_sum[i]  = acc_en ? (lane_base[i] + lane_a[i] + lane_b[i])
                                  : (lane_a[i] + lane_b[i]);
            acc_d[i]     = (accept & acc_en) ? lane_sum[i] : lane_base[i];
            sum_dat[i*(WIDTH+1) +: WIDTH+1] = lane_sum[i];
            xor_dat[i*WIDTH +: WIDTH] = in_b[i*WIDTH +: WIDTH] ^ in_c[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        sample_cnt_d = sample_cnt_q + 16'(accept);
        hold_d       = pop ? head_dat : hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            sample_cnt_q <= '0;
            hold_q       <= '0;
        end else begin
            acc_q        <= acc_d;
            sample_cnt_q <= sample_cnt_d;
            hold_q       <= hold_d;
        end
    end

    sub_c_pipe_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (accept),
        .wr_dat ({sum_dat, xor_dat}),
        .rd_rdy (out_ready),
        .rd_dat (head_dat),
        .level  (fifo_level),
        .full   (full),
        .empty  (empty)
    );

    // When empty the outputs keep showing the last entry that left.
    assign {out_sum, out_xor} = out_valid ? head_dat : hold_q;
    assign sample_cnt = sample_cnt_q;
endmodule

// File: tb/tb_sub_c_pipe.sv
// Randomised and directed stimulus for sub_c_pipe, checked every cycle against a queue-based reference model.
module tb_sub_c_pipe;
    localparam int W = 8, CH = 2, D = 4;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, acc_en, acc_clr, out_valid, out_ready;
    logic [15:0] in_a, in_b, in_c, out_xor, sample_cnt;
    logic [17:0] out_sum;
    logic [2:0]  fifo_level;

    typedef struct packed { logic [17:0] s; logic [15:0] x; } ent_t;
    ent_t        q[$];
    ent_t        hold;
    int unsigned acc_m[CH];
    logic [15:0] cnt_m, c0;
    int          checks = 0, errors = 0;

    sub_c_pipe #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_xor(out_xor),
        .fifo_level(fifo_level), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        hold  = '0;
        cnt_m = '0;
        for (int i = 0; i < CH; i++) acc_m[i] = 0;
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("fifo_level", 32'(fifo_level), q.size());
        chk("in_ready", 32'(in_ready), 32'(rst_n && q.size() != D));
        chk("sample_cnt", 32'(sample_cnt), 32'(cnt_m));
        if (q.size() != 0) begin
            chk("out_sum", 32'(out_sum), 32'(q[0].s));
            chk("out_xor", 32'(out_xor), 32'(q[0].x));
        end else begin
            chk("hold_sum", 32'(out_sum), 32'(hold.s));
            chk("hold_xor", 32'(out_xor), 32'(hold.x));
        end
    endtask

    // One clock: decide the edge's events from current inputs, apply them after the edge, check at negedge.
    task automatic cycle();
        bit          acc, pp;
        ent_t        e;
        int unsigned a, b, c, s;
        int unsigned nacc[CH];
        acc = rst_n && in_valid && (q.size() < D);
        pp  = rst_n && out_ready && (q.size() > 0);
        e   = '0;
        for (int i = 0; i < CH; i++) begin
            a = in_a[i*W +: W];
            b = in_b[i*W +: W];
            c = in_c[i*W +: W];
            s = acc_en ? (((acc_clr ? 0 : acc_m[i]) + a + b) % 512) : (a + b);
            e.s[i*9 +: 9] = 9'(s);
            e.x[i*W +: W] = 8'(b ^ c);
            nacc[i] = (acc && acc_en) ? s : (acc_clr ? 0 : acc_m[i]);
        end
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            if (pp) hold = q.pop_front();
            if (acc) begin
                q.push_back(e);
                cnt_m = cnt_m + 16'd1;
            end
            for (int i = 0; i < CH; i++) acc_m[i] = nacc[i];
        end
        @(negedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic ordy, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic en, input logic clr);
        in_valid = v; out_ready = ordy; in_a = a; in_b = b; in_c = c; acc_en = en; acc_clr = clr;
    endtask

    task automatic drive_rand(input logic v, input logic ordy);
        drive(v, ordy, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        check_all();
        chk("reset_in_ready", 32'(in_ready), 0);
        chk("reset_out_sum", 32'(out_sum), 0);
        cycle();
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 1);

        // T2 basic
        drive(1, 1, {8'h01, 8'hFF}, {8'h02, 8'h01}, {8'h03, 8'h0F}, 0, 0);
        cycle();
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_sum", 32'(out_sum), 32'({9'h003, 9'h100}));
        chk("t2_xor", 32'(out_xor), 32'({8'h01, 8'h0E}));
        drive_rand(0, 1);
        cycle();
        chk("t2_hold_sum", 32'(out_sum), 32'({9'h003, 9'h100}));

        // T1 reset with 3 entries queued
        for (int i = 0; i < 3; i++) begin
            drive_rand(1, 0);
            cycle();
        end
        chk("t1_level3", 32'(fifo_level), 3);
        drive_rand(0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("t1_valid_low", 32'(out_valid), 0);
        chk("t1_level_low", 32'(fifo_level), 0);
        chk("t1_ready_low", 32'(in_ready), 0);
        cycle();
        chk("t1_ready_low2", 32'(in_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("t1_ready_release", 32'(in_ready), 1);

        // T3 back-pressure
        for (int i = 0; i < 5; i++) begin
            drive_rand(1, 0);
            cycle();
        end
        chk("t3_level_full", 32'(fifo_level), 4);
        chk("t3_ready_full", 32'(in_ready), 0);
        drive_rand(1, 1);
        cycle();
        chk("t3_no_bypass", 32'(fifo_level), 3);
        chk("t3_ready_after_pop", 32'(in_ready), 1);
        drive_rand(0, 1);
        for (int i = 0; i < 4; i++) cycle();
        chk("t3_drained", 32'(out_valid), 0);

        // T4 accumulate with wrap
        drive(1, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 1);
        cycle();
        chk("t4_s1", 32'(out_sum), 32'({9'h1FE, 9'h1FE}));
        drive(1, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 0);
        cycle();
        chk("t4_s2", 32'(out_sum), 32'({9'h1FC, 9'h1FC}));
        cycle();
        chk("t4_s3", 32'(out_sum), 32'({9'h1FA, 9'h1FA}));
        drive_rand(0, 1);
        cycle();

        // T5 simultaneous push/pop at level 2
        for (int i = 0; i < 2; i++) begin
            drive_rand(1, 0);
            cycle();
        end
        c0 = cnt_m;
        for (int i = 0; i < 10; i++) begin
            drive_rand(1, 1);
            cycle();
            chk("t5_level", 32'(fifo_level), 2);
        end
        chk("t5_cnt", 32'(sample_cnt), 32'(c0 + 16'd10));

        // Random mix, including accumulate and sporadic clears
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  1'($urandom), ($urandom_range(0, 7) == 0));
            cycle();
        end

        // T6 counter wrap from reset
        drive_rand(0, 0);
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            drive_rand(1, 1);
            cycle();
        end
        chk("t6_wrap", 32'(sample_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
